// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: FSM state encoding and the
// sample width, which matches the upstream stage's X output.
package result_collector_pkg;

    localparam int unsigned RESULT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

endpackage

// File: rtl/result_collector_sample_store.sv
// sample_store: DEPTH x RESULT_W register file with one write port and one
// registered read port. Array contents are not reset; only the read register is.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata : write port, written on the rising edge when we is high
//   raddr, rdata     : rdata <= mem[raddr] every cycle (latency 1)
module sample_store
    import result_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [RESULT_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [RESULT_W-1:0] rdata
);

    logic [RESULT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/result_collector.sv
// result_collector: captures bursts of X/X_VALID samples into a local store
// and keeps running SUM, COUNT and MAX. A burst ends when the store is full or
// after TIMEOUT idle cycles following at least one sample; DONE pulses once on
// entry to the report state. Armed by START, aborted by HALT.
//   CLK, RSTN        : clock, asynchronous active-low reset
//   START, HALT      : arm pulse (idle/report only), synchronous abort
//   X, X_VALID       : sample stream from the upstream stage
//   RD_ADDR, RD_DATA : registered readback of the sample store
//   SUM, COUNT, MAX  : registered burst statistics
//   BUSY, DONE       : collecting flag, end-of-burst pulse
//   OVERRUN          : sticky, X_VALID seen in the report state
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   START,
    input  logic                   HALT,
    input  logic [RESULT_W-1:0]    X,
    input  logic                   X_VALID,
    input  logic [AW-1:0]          RD_ADDR,
    output logic [RESULT_W-1:0]    RD_DATA,
    output logic [RESULT_W+AW:0]   SUM,
    output logic [AW:0]            COUNT,
    output logic [RESULT_W-1:0]    MAX,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVERRUN
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = RESULT_W + AW + 1;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_inc;
    logic [CW-1:0] count_inc;
    logic          arm;
    logic          store_we;

    assign idle_inc  = idle_cnt + IW'(1);
    assign count_inc = COUNT + CW'(1);
    assign arm       = START && (state != S_COLLECT);
    // HALT discards a sample arriving in the same cycle
    assign store_we  = (state == S_COLLECT) && X_VALID && !HALT;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
            SUM      <= '0;
            COUNT    <= '0;
            MAX      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (HALT) begin
                state    <= S_IDLE;
                idle_cnt <= '0;
                SUM      <= '0;
                COUNT    <= '0;
                MAX      <= '0;
                BUSY     <= 1'b0;
                OVERRUN  <= 1'b0;
            end else if (arm) begin
                state    <= S_COLLECT;
                idle_cnt <= '0;
                SUM      <= '0;
                COUNT    <= '0;
                MAX      <= '0;
                BUSY     <= 1'b1;
                OVERRUN  <= 1'b0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        if (X_VALID) begin
                            SUM      <= SUM + SW'(X);
                            COUNT    <= count_inc;
                            idle_cnt <= '0;
                            if (X > MAX) begin
                                MAX <= X;
                            end
                            if (count_inc == CW'(DEPTH)) begin
                                state <= S_REPORT;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end else if (COUNT != '0) begin
                            // idle timeout only runs once the burst has started
                            idle_cnt <= idle_inc;
                            if (idle_inc == IW'(TIMEOUT)) begin
                                state <= S_REPORT;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end
                        end
                    end
                    S_REPORT: begin
                        if (X_VALID) begin
                            OVERRUN <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sample_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk   (CLK),
        .rst_n (RSTN),
        .we    (store_we),
        .waddr (COUNT[AW-1:0]),
        .wdata (X),
        .raddr (RD_ADDR),
        .rdata (RD_DATA)
    );

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned AW      = 3;

    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_REPORT  = 2;

    logic          CLK;
    logic          RSTN;
    logic          START;
    logic          HALT;
    logic [15:0]   X;
    logic          X_VALID;
    logic [AW-1:0] RD_ADDR;
    logic [15:0]   RD_DATA;
    logic [19:0]   SUM;
    logic [AW:0]   COUNT;
    logic [15:0]   MAX;
    logic          BUSY;
    logic          DONE;
    logic          OVERRUN;

    result_collector #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .START   (START),
        .HALT    (HALT),
        .X       (X),
        .X_VALID (X_VALID),
        .RD_ADDR (RD_ADDR),
        .RD_DATA (RD_DATA),
        .SUM     (SUM),
        .COUNT   (COUNT),
        .MAX     (MAX),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .OVERRUN (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model: burst contents as a queue, statistics derived from it
    logic [15:0] q[$];
    int          m_phase;
    int unsigned m_gap;
    bit          m_done;
    bit          m_over;
    logic [15:0] m_store [DEPTH];
    bit          m_written [DEPTH];
    logic [15:0] m_rd;
    bit          m_rd_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned q_sum();
        int unsigned s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    function automatic int unsigned q_max();
        int unsigned m = 0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_phase    = PH_IDLE;
        m_gap      = 0;
        m_done     = 0;
        m_over     = 0;
        m_rd       = '0;
        m_rd_known = 1;
    endtask

    task automatic model_update(input bit st, input bit hl, input bit xv,
                                input logic [15:0] xd, input logic [AW-1:0] ra);
        m_rd_known = m_written[ra];
        m_rd       = m_store[ra];
        m_done     = 0;
        if (hl) begin
            m_phase = PH_IDLE;
            q.delete();
            m_over = 0;
            m_gap  = 0;
        end else if (st && m_phase != PH_COLLECT) begin
            m_phase = PH_COLLECT;
            q.delete();
            m_over = 0;
            m_gap  = 0;
        end else if (m_phase == PH_COLLECT) begin
            if (xv) begin
                m_store[q.size()]   = xd;
                m_written[q.size()] = 1;
                q.push_back(xd);
                m_gap = 0;
                if (q.size() == DEPTH) begin
                    m_phase = PH_REPORT;
                    m_done  = 1;
                end
            end else if (q.size() != 0) begin
                m_gap++;
                if (m_gap == TIMEOUT) begin
                    m_phase = PH_REPORT;
                    m_done  = 1;
                end
            end
        end else if (m_phase == PH_REPORT && xv) begin
            m_over = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("sum",     32'(SUM),     q_sum());
        check_eq("count",   32'(COUNT),   q.size());
        check_eq("max",     32'(MAX),     q_max());
        check_eq("busy",    32'(BUSY),    32'(m_phase == PH_COLLECT));
        check_eq("done",    32'(DONE),    32'(m_done));
        check_eq("overrun", 32'(OVERRUN), 32'(m_over));
        if (m_rd_known) check_eq("rd_data", 32'(RD_DATA), 32'(m_rd));
    endtask

    // drive one cycle of inputs, advance the model at the edge, check after it
    task automatic step(input bit st, input bit hl, input bit xv,
                        input logic [15:0] xd, input logic [AW-1:0] ra);
        START   = st;
        HALT    = hl;
        X_VALID = xv;
        X       = xd;
        RD_ADDR = ra;
        @(posedge CLK);
        model_update(st, hl, xv, xd, ra);
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int unsigned n, input logic [AW-1:0] ra);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 16'h0, ra);
    endtask

    initial begin
        int unsigned quiet;
        foreach (m_written[i]) m_written[i] = 0;
        RSTN = 1'b0; START = 0; HALT = 0; X_VALID = 0; X = '0; RD_ADDR = '0;
        model_reset();
        #12;
        check_eq("rst_sum",  32'(SUM),  0);
        check_eq("rst_count", 32'(COUNT), 0);
        check_eq("rst_busy", 32'(BUSY), 0);
        check_eq("rst_done", 32'(DONE), 0);
        check_eq("rst_rd",   32'(RD_DATA), 0);
        @(posedge CLK); #1;
        RSTN = 1'b1;

        // basic burst
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 3, 1);
        step(0, 0, 1, 10, 1);
        step(0, 0, 1, 7, 1);
        idle_cycles(TIMEOUT - 1, 1);
        check_eq("basic_no_early_done", 32'(DONE), 0);
        step(0, 0, 0, 0, 1);
        check_eq("basic_done", 32'(DONE), 1);
        check_eq("basic_sum",  32'(SUM), 20);
        check_eq("basic_count", 32'(COUNT), 3);
        check_eq("basic_max",  32'(MAX), 10);
        check_eq("basic_rd1",  32'(RD_DATA), 10);
        step(0, 0, 0, 0, 1);
        check_eq("basic_done_pulse", 32'(DONE), 0);

        // re-arm from report with stale statistics
        step(1, 0, 0, 0, 0);
        check_eq("rearm_sum", 32'(SUM), 0);
        check_eq("rearm_busy", 32'(BUSY), 1);
        step(0, 0, 1, 5, 0);
        check_eq("rearm_sum5", 32'(SUM), 5);
        check_eq("rearm_count", 32'(COUNT), 1);
        check_eq("rearm_max", 32'(MAX), 5);
        idle_cycles(TIMEOUT, 0);

        // full store
        step(1, 0, 0, 0, 7);
        for (int unsigned i = 0; i < DEPTH; i++) step(0, 0, 1, 16'hFFFF, 7);
        check_eq("full_done",  32'(DONE), 1);
        check_eq("full_sum",   32'(SUM), 32'h7FFF8);
        check_eq("full_count", 32'(COUNT), 8);
        check_eq("full_max",   32'(MAX), 32'hFFFF);
        step(0, 0, 1, 16'h1234, 7);
        check_eq("full_overrun", 32'(OVERRUN), 1);
        check_eq("full_count_hold", 32'(COUNT), 8);

        // gapped burst
        step(1, 0, 0, 0, 2);
        for (int unsigned i = 0; i < 3; i++) begin
            step(0, 0, 1, 16'(100 + i), 2);
            if (i < 2) idle_cycles(TIMEOUT - 1, 2);
        end
        check_eq("gap_busy",  32'(BUSY), 1);
        check_eq("gap_count", 32'(COUNT), 3);
        idle_cycles(TIMEOUT, 2);
        check_eq("gap_done",  32'(DONE), 1);
        check_eq("gap_sum",   32'(SUM), 303);

        // halt mid-burst with a colliding sample
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 11, 0);
        step(0, 0, 1, 12, 0);
        step(0, 1, 1, 99, 0);
        check_eq("halt_count", 32'(COUNT), 0);
        check_eq("halt_sum",   32'(SUM), 0);
        check_eq("halt_busy",  32'(BUSY), 0);
        check_eq("halt_done",  32'(DONE), 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 4, 0);
        idle_cycles(TIMEOUT, 0);
        check_eq("halt_restart_sum", 32'(SUM), 4);

        // asynchronous reset mid-burst
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 6, 0);
        step(0, 0, 1, 1, 0);
        #3;
        RSTN = 1'b0;
        #1;
        check_eq("arst_sum",   32'(SUM), 0);
        check_eq("arst_count", 32'(COUNT), 0);
        check_eq("arst_max",   32'(MAX), 0);
        check_eq("arst_busy",  32'(BUSY), 0);
        check_eq("arst_rd",    32'(RD_DATA), 0);
        START = 1;
        @(posedge CLK); #1;
        check_eq("arst_start_ignored", 32'(BUSY), 0);
        START = 0;
        RSTN  = 1'b1;
        model_reset();
        step(0, 0, 1, 9, 0);
        check_eq("arst_idle_no_capture", 32'(COUNT), 0);

        // randomized traffic
        quiet = 0;
        for (int unsigned c = 0; c < 1500; c++) begin
            int unsigned r;
            bit xv;
            r  = $urandom_range(0, 99);
            xv = (quiet == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (quiet != 0) quiet--;
            else if (r >= 8 && r < 12) quiet = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            step(r < 8, r >= 97, xv, 16'($urandom), AW'($urandom_range(0, DEPTH - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
